dcache_ctrl: RTL and testbench

//  Upstream controller for the 64-set 2-way Dcache: accepts loads/stores from the LSQ and probes the Dcache read port.

---
 rtl/dcache_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Upstream controller for a 64-set 2-way Dcache. Accepts loads and
//            stores from the LSQ, probes the Dcache read port, returns load
//            hits, issues misses and write-through stores to memory, tracks
//            outstanding load misses in MSHRs and writes fills (port B) and
//            stores (port A) into the Dcache.
// Ports    : clock/reset                 - clock, async active-high reset
//            lsq_req_* / lsq_req_ready   - LSQ request handshake
//            ld_resp_*                   - registered load response pulse
//            dc_rd_*                     - same-cycle Dcache probe
//            dc_wrA_* / dc_wrB_*         - store write / fill write
//            proc2mem_* / mem2proc_*     - memory command and fill interface
//            perf_hits/perf_misses       - present only with DCTRL_PERF_CNT_EN
// Options  : define DCTRL_PERF_CNT_EN to add load hit/miss counters
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
   parameter int NUM_MSHR  = 4,
   parameter int ID_W      = 5,
   parameter int MEM_TAG_W = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 lsq_req_valid,
   input  logic                 lsq_req_is_store,
   input  logic [63:0]          lsq_req_addr,
   input  logic [63:0]          lsq_req_data,
   input  logic [ID_W-1:0]      lsq_req_id,
   output logic                 lsq_req_ready,
   output logic                 ld_resp_valid,
   output logic [ID_W-1:0]      ld_resp_id,
   output logic [63:0]          ld_resp_data,
   output logic [5:0]           dc_rd_idx,
   output logic [54:0]          dc_rd_tag,
   input  logic [63:0]          dc_rd_data,
   input  logic                 dc_rd_valid,
   output logic                 dc_wrA_en,
   output logic [5:0]           dc_wrA_idx,
   output logic [54:0]          dc_wrA_tag,
   output logic [63:0]          dc_wrA_data,
   output logic                 dc_wrB_en,
   output logic [5:0]           dc_wrB_idx,
   output logic [54:0]          dc_wrB_tag,
   output logic [63:0]          dc_wrB_data,
   output logic [1:0]           proc2mem_command,
   output logic [63:0]          proc2mem_addr,
   output logic [63:0]          proc2mem_data,
   input  logic [MEM_TAG_W-1:0] mem2proc_response,
   input  logic [63:0]          mem2proc_data,
   input  logic [MEM_TAG_W-1:0] mem2proc_tag
`ifdef DCTRL_PERF_CNT_EN
   ,
   output logic [31:0]          perf_hits,
   output logic [31:0]          perf_misses
`endif
);

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam int         MIDX_W    = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, BUS_REQ = 1'b1} state_t;

   state_t                state_q, state_d;
   // MSHR file; blk holds addr[63:3] = {tag, idx}. A mem tag of 0 means the
   // bus has not yet accepted the miss, so no fill can match it.
   logic [NUM_MSHR-1:0]   mshr_valid_q, mshr_valid_d;
   logic [NUM_MSHR-1:0]   mshr_nofill_q, mshr_nofill_d;
   logic [60:0]           mshr_blk_q [NUM_MSHR];
   logic [60:0]           mshr_blk_d [NUM_MSHR];
   logic [ID_W-1:0]       mshr_id_q  [NUM_MSHR];
   logic [ID_W-1:0]       mshr_id_d  [NUM_MSHR];
   logic [MEM_TAG_W-1:0]  mshr_tag_q [NUM_MSHR];
   logic [MEM_TAG_W-1:0]  mshr_tag_d [NUM_MSHR];
   // Hold register for the request currently on the bus
   logic                  hold_store_q, hold_store_d;
   logic [60:0]           hold_blk_q, hold_blk_d;
   logic [63:0]           hold_data_q, hold_data_d;
   logic [MIDX_W-1:0]     hold_k_q, hold_k_d;
   logic                  ld_resp_valid_d;
   logic [ID_W-1:0]       ld_resp_id_d;
   logic [63:0]           ld_resp_data_d;

   logic                  fill_hit, blk_pending, mshr_full, free_found, accept, mem_acc;
   logic [MIDX_W-1:0]     fill_k, free_k;
   logic [NUM_MSHR-1:0]   blk_match;
   logic [60:0]           req_blk;
   logic                  unused_addr_bits;

   assign req_blk          = lsq_req_addr[63:3];
   assign unused_addr_bits = ^lsq_req_addr[2:0];

`ifdef DCTRL_PERF_CNT_EN
   logic [31:0] perf_hits_q, perf_hits_d, perf_misses_q, perf_misses_d;
   assign perf_hits   = perf_hits_q;
   assign perf_misses = perf_misses_q;
`endif

   always_comb begin
      state_d         = state_q;
      mshr_valid_d    = mshr_valid_q;
      mshr_nofill_d   = mshr_nofill_q;
      mshr_blk_d      = mshr_blk_q;
      mshr_id_d       = mshr_id_q;
      mshr_tag_d      = mshr_tag_q;
      hold_store_d    = hold_store_q;
      hold_blk_d      = hold_blk_q;
      hold_data_d     = hold_data_q;
      hold_k_d        = hold_k_q;
      ld_resp_valid_d = 1'b0;
      ld_resp_id_d    = '0;
      ld_resp_data_d  = '0;
      fill_hit        = 1'b0;
      fill_k          = '0;
      free_found      = 1'b0;
      free_k          = '0;
      blk_match       = '0;
      dc_wrA_en       = 1'b0;
      dc_wrA_idx      = '0;
      dc_wrA_tag      = '0;
      dc_wrA_data     = '0;
      dc_wrB_en       = 1'b0;
      dc_wrB_idx      = '0;
      dc_wrB_tag      = '0;
      dc_wrB_data     = '0;
      proc2mem_command = BUS_NONE;
      proc2mem_addr   = '0;
      proc2mem_data   = '0;
`ifdef DCTRL_PERF_CNT_EN
      perf_hits_d     = perf_hits_q;
      perf_misses_d   = perf_misses_q;
`endif

      for (int k = 0; k < NUM_MSHR; k++) begin
         if (!fill_hit && mshr_valid_q[k] && (mem2proc_tag != '0) &&
             (mshr_tag_q[k] == mem2proc_tag)) begin
            fill_hit = 1'b1;
            fill_k   = MIDX_W'(k);
         end
         if (!free_found && !mshr_valid_q[k]) begin
            free_found = 1'b1;
            free_k     = MIDX_W'(k);
         end
         blk_match[k] = mshr_valid_q[k] && (mshr_blk_q[k] == req_blk);
      end

      mshr_full     = &mshr_valid_q;
      // Secondary load misses stall until the primary fill returns
      blk_pending   = lsq_req_valid && !lsq_req_is_store && (|blk_match);
      lsq_req_ready = !reset && (state_q == IDLE) && !mshr_full && !fill_hit && !blk_pending;
      accept        = lsq_req_valid && lsq_req_ready;
      mem_acc       = (state_q == BUS_REQ) && (mem2proc_response != '0);

      dc_rd_idx = reset ? '0 : lsq_req_addr[8:3];
      dc_rd_tag = reset ? '0 : lsq_req_addr[63:9];

      if (state_q == BUS_REQ) begin
         proc2mem_command = hold_store_q ? BUS_STORE : BUS_LOAD;
         proc2mem_addr    = {hold_blk_q, 3'b000};
         proc2mem_data    = hold_store_q ? hold_data_q : '0;
      end

      if (mem_acc) begin
         state_d = IDLE;
         if (hold_store_q) begin
            dc_wrA_en   = 1'b1;
            dc_wrA_idx  = hold_blk_q[5:0];
            dc_wrA_tag  = hold_blk_q[60:6];
            dc_wrA_data = hold_data_q;
         end else begin
            mshr_tag_d[hold_k_q] = mem2proc_response;
         end
      end

      if (fill_hit) begin
         dc_wrB_en   = !mshr_nofill_q[fill_k];
         dc_wrB_idx  = dc_wrB_en ? mshr_blk_q[fill_k][5:0]  : '0;
         dc_wrB_tag  = dc_wrB_en ? mshr_blk_q[fill_k][60:6] : '0;
         dc_wrB_data = dc_wrB_en ? mem2proc_data            : '0;
         ld_resp_valid_d        = 1'b1;
         ld_resp_id_d           = mshr_id_q[fill_k];
         ld_resp_data_d         = mem2proc_data;
         mshr_valid_d[fill_k]   = 1'b0;
         mshr_nofill_d[fill_k]  = 1'b0;
      end

      // Accept never coincides with a fill or a bus cycle (ready is low then)
      if (accept) begin
         if (lsq_req_is_store) begin
            hold_store_d  = 1'b1;
            hold_blk_d    = req_blk;
            hold_data_d   = lsq_req_data;
            // Memory returns the pre-store data for older misses; keep it out of the cache
            mshr_nofill_d = mshr_nofill_q | blk_match;
            state_d       = BUS_REQ;
         end else if (dc_rd_valid) begin
            ld_resp_valid_d = 1'b1;
            ld_resp_id_d    = lsq_req_id;
            ld_resp_data_d  = dc_rd_data;
`ifdef DCTRL_PERF_CNT_EN
            perf_hits_d     = perf_hits_q + 32'd1;
`endif
         end else begin
            hold_store_d          = 1'b0;
            hold_blk_d            = req_blk;
            hold_data_d           = '0;
            hold_k_d              = free_k;
            mshr_valid_d[free_k]  = 1'b1;
            mshr_nofill_d[free_k] = 1'b0;
            mshr_blk_d[free_k]    = req_blk;
            mshr_id_d[free_k]     = lsq_req_id;
            mshr_tag_d[free_k]    = '0;
            state_d               = BUS_REQ;
`ifdef DCTRL_PERF_CNT_EN
            perf_misses_d         = perf_misses_q + 32'd1;
`endif
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         mshr_valid_q  <= '0;
         mshr_nofill_q <= '0;
         for (int k = 0; k < NUM_MSHR; k++) begin
            mshr_blk_q[k] <= '0;
            mshr_id_q[k]  <= '0;
            mshr_tag_q[k] <= '0;
         end
         hold_store_q  <= 1'b0;
         hold_blk_q    <= '0;
         hold_data_q   <= '0;
         hold_k_q      <= '0;
         ld_resp_valid <= 1'b0;
         ld_resp_id    <= '0;
         ld_resp_data  <= '0;
`ifdef DCTRL_PERF_CNT_EN
         perf_hits_q   <= '0;
         perf_misses_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         mshr_valid_q  <= mshr_valid_d;
         mshr_nofill_q <= mshr_nofill_d;
         mshr_blk_q    <= mshr_blk_d;
         mshr_id_q     <= mshr_id_d;
         mshr_tag_q    <= mshr_tag_d;
         hold_store_q  <= hold_store_d;
         hold_blk_q    <= hold_blk_d;
         hold_data_q   <= hold_data_d;
         hold_k_q      <= hold_k_d;
         ld_resp_valid <= ld_resp_valid_d;
         ld_resp_id    <= ld_resp_id_d;
         ld_resp_data  <= ld_resp_data_d;
`ifdef DCTRL_PERF_CNT_EN
         perf_hits_q   <= perf_hits_d;
         perf_misses_q <= perf_misses_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Directed self-checking bench for dcache_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
   localparam int ID_W      = 5;
   localparam int MEM_TAG_W = 4;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 lsq_req_valid, lsq_req_is_store, lsq_req_ready;
   logic [63:0]          lsq_req_addr, lsq_req_data;
   logic [ID_W-1:0]      lsq_req_id;
   logic                 ld_resp_valid;
   logic [ID_W-1:0]      ld_resp_id;
   logic [63:0]          ld_resp_data;
   logic [5:0]           dc_rd_idx, dc_wrA_idx, dc_wrB_idx;
   logic [54:0]          dc_rd_tag, dc_wrA_tag, dc_wrB_tag;
   logic [63:0]          dc_rd_data, dc_wrA_data, dc_wrB_data;
   logic                 dc_rd_valid, dc_wrA_en, dc_wrB_en;
   logic [1:0]           proc2mem_command;
   logic [63:0]          proc2mem_addr, proc2mem_data, mem2proc_data;
   logic [MEM_TAG_W-1:0] mem2proc_response, mem2proc_tag;
`ifdef DCTRL_PERF_CNT_EN
   logic [31:0]          perf_hits, perf_misses;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   dcache_ctrl #(.NUM_MSHR(4), .ID_W(ID_W), .MEM_TAG_W(MEM_TAG_W)) dut (
      .clock(clock), .reset(reset),
      .lsq_req_valid(lsq_req_valid), .lsq_req_is_store(lsq_req_is_store),
      .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data),
      .lsq_req_id(lsq_req_id), .lsq_req_ready(lsq_req_ready),
      .ld_resp_valid(ld_resp_valid), .ld_resp_id(ld_resp_id), .ld_resp_data(ld_resp_data),
      .dc_rd_idx(dc_rd_idx), .dc_rd_tag(dc_rd_tag),
      .dc_rd_data(dc_rd_data), .dc_rd_valid(dc_rd_valid),
      .dc_wrA_en(dc_wrA_en), .dc_wrA_idx(dc_wrA_idx), .dc_wrA_tag(dc_wrA_tag), .dc_wrA_data(dc_wrA_data),
      .dc_wrB_en(dc_wrB_en), .dc_wrB_idx(dc_wrB_idx), .dc_wrB_tag(dc_wrB_tag), .dc_wrB_data(dc_wrB_data),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
`ifdef DCTRL_PERF_CNT_EN
      , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
   );

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      lsq_req_valid     = 1'b0;
      lsq_req_is_store  = 1'b0;
      lsq_req_addr      = '0;
      lsq_req_data      = '0;
      lsq_req_id        = '0;
      dc_rd_data        = '0;
      dc_rd_valid       = 1'b0;
      mem2proc_response = '0;
      mem2proc_data     = '0;
      mem2proc_tag      = '0;
   endtask

   task automatic drive_req(input logic st, input logic [63:0] a, input logic [63:0] d,
                            input logic [ID_W-1:0] id, input logic hit, input logic [63:0] rd);
      lsq_req_valid    = 1'b1;
      lsq_req_is_store = st;
      lsq_req_addr     = a;
      lsq_req_data     = d;
      lsq_req_id       = id;
      dc_rd_valid      = hit;
      dc_rd_data       = rd;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #2;
      checks++; if (lsq_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", lsq_req_ready); end
      checks++; if (ld_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b want 0", ld_resp_valid); end
      checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL reset_cmd: got %0d want 0", proc2mem_command); end
      checks++; if ({dc_wrA_en, dc_wrB_en} !== 2'b00) begin errors++; $display("FAIL reset_wr_en: got %b want 00", {dc_wrA_en, dc_wrB_en}); end
      step();
      step();
      reset = 1'b0;
      #1;
      checks++; if (lsq_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b want 1", lsq_req_ready); end
   endtask

   task automatic test_load_hit();
      drive_req(1'b0, 64'h1000, 64'h0, 5'd7, 1'b1, 64'hAA);
      #1;
      checks++; if (lsq_req_ready !== 1'b1) begin errors++; $display("FAIL hit_ready: got %0b want 1", lsq_req_ready); end
      checks++; if (dc_rd_idx !== 6'd0 || dc_rd_tag !== 55'd8) begin errors++; $display("FAIL hit_probe: got idx %0d tag %0h want 0 8", dc_rd_idx, dc_rd_tag); end
      step();
      idle_inputs();
      #1;
      checks++; if (ld_resp_valid !== 1'b1 || ld_resp_data !== 64'hAA || ld_resp_id !== 5'd7) begin
         errors++; $display("FAIL hit_resp: got v%0b id%0d data %0h want v1 id7 data aa", ld_resp_valid, ld_resp_id, ld_resp_data); end
      checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL hit_no_bus: got %0d want 0", proc2mem_command); end
      step();
      checks++; if (ld_resp_valid !== 1'b0) begin errors++; $display("FAIL hit_pulse: got %0b want 0", ld_resp_valid); end
   endtask

   task automatic test_load_miss();
      drive_req(1'b0, 64'h2008, 64'h0, 5'd3, 1'b0, 64'h0);
      step();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         if (c == 2) mem2proc_response = 4'd3;
         #1;
         checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h2008) begin
            errors++; $display("FAIL miss_cmd_c%0d: got cmd %0d addr %0h want 1 2008", c, proc2mem_command, proc2mem_addr); end
         step();
      end
      mem2proc_response = '0;
      #1;
      checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL miss_cmd_drop: got %0d want 0", proc2mem_command); end
      mem2proc_tag  = 4'd3;
      mem2proc_data = 64'h55;
      #1;
      checks++; if (dc_wrB_en !== 1'b1 || dc_wrB_idx !== 6'd1 || dc_wrB_tag !== 55'd16 || dc_wrB_data !== 64'h55) begin
         errors++; $display("FAIL miss_wrB: got en%0b idx%0d tag%0h data%0h want 1 1 10 55", dc_wrB_en, dc_wrB_idx, dc_wrB_tag, dc_wrB_data); end
      checks++; if (lsq_req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b want 0", lsq_req_ready); end
      step();
      mem2proc_tag = '0;
      checks++; if (ld_resp_valid !== 1'b1 || ld_resp_id !== 5'd3 || ld_resp_data !== 64'h55) begin
         errors++; $display("FAIL miss_resp: got v%0b id%0d data %0h want v1 id3 data 55", ld_resp_valid, ld_resp_id, ld_resp_data); end
   endtask

   task automatic test_mshr_full();
      logic [MEM_TAG_W-1:0] tg [3];
      logic [ID_W-1:0]      ex [3];
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b0, 64'h4000 + 64'(8 * i), 64'h0, 5'(10 + i), 1'b0, 64'h0);
         step();
         idle_inputs();
         mem2proc_response = 4'(i + 1);
         step();
         mem2proc_response = '0;
      end
      drive_req(1'b0, 64'h5000, 64'h0, 5'd20, 1'b0, 64'h0);
      #1;
      checks++; if (lsq_req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", lsq_req_ready); end
      idle_inputs();
      mem2proc_tag  = 4'd2;
      mem2proc_data = 64'h22;
      #1;
      checks++; if (dc_wrB_en !== 1'b1 || dc_wrB_idx !== 6'd1) begin errors++; $display("FAIL full_wrB: got en%0b idx%0d want 1 1", dc_wrB_en, dc_wrB_idx); end
      step();
      mem2proc_tag = '0;
      checks++; if (ld_resp_valid !== 1'b1 || ld_resp_id !== 5'd11 || ld_resp_data !== 64'h22) begin
         errors++; $display("FAIL full_resp: got v%0b id%0d data %0h want v1 id11 data 22", ld_resp_valid, ld_resp_id, ld_resp_data); end
      #1;
      checks++; if (lsq_req_ready !== 1'b1) begin errors++; $display("FAIL freed_ready: got %0b want 1", lsq_req_ready); end
      tg[0] = 4'd1; tg[1] = 4'd3; tg[2] = 4'd4;
      ex[0] = 5'd10; ex[1] = 5'd12; ex[2] = 5'd13;
      for (int j = 0; j < 3; j++) begin
         mem2proc_tag = tg[j];
         step();
         mem2proc_tag = '0;
         checks++; if (ld_resp_valid !== 1'b1 || ld_resp_id !== ex[j]) begin
            errors++; $display("FAIL drain_%0d: got v%0b id%0d want v1 id%0d", j, ld_resp_valid, ld_resp_id, ex[j]); end
      end
   endtask

   task automatic test_store_nofill();
      drive_req(1'b0, 64'h3000, 64'h0, 5'd5, 1'b0, 64'h0);
      step();
      idle_inputs();
      mem2proc_response = 4'd6;
      step();
      mem2proc_response = '0;
      drive_req(1'b1, 64'h3000, 64'h77, 5'd0, 1'b0, 64'h0);
      #1;
      checks++; if (lsq_req_ready !== 1'b1) begin errors++; $display("FAIL store_ready: got %0b want 1", lsq_req_ready); end
      step();
      idle_inputs();
      mem2proc_response = 4'd7;
      #1;
      checks++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== 64'h3000 || proc2mem_data !== 64'h77) begin
         errors++; $display("FAIL store_cmd: got %0d %0h %0h want 2 3000 77", proc2mem_command, proc2mem_addr, proc2mem_data); end
      checks++; if (dc_wrA_en !== 1'b1 || dc_wrA_data !== 64'h77 || dc_wrA_idx !== 6'd0 || dc_wrA_tag !== 55'd24) begin
         errors++; $display("FAIL store_wrA: got en%0b data%0h idx%0d tag%0h want 1 77 0 18", dc_wrA_en, dc_wrA_data, dc_wrA_idx, dc_wrA_tag); end
      step();
      mem2proc_response = '0;
      mem2proc_tag      = 4'd6;
      mem2proc_data     = 64'h11;
      #1;
      checks++; if (dc_wrB_en !== 1'b0) begin errors++; $display("FAIL nofill_wrB: got %0b want 0", dc_wrB_en); end
      step();
      mem2proc_tag = '0;
      checks++; if (ld_resp_valid !== 1'b1 || ld_resp_id !== 5'd5 || ld_resp_data !== 64'h11) begin
         errors++; $display("FAIL nofill_resp: got v%0b id%0d data %0h want v1 id5 data 11", ld_resp_valid, ld_resp_id, ld_resp_data); end
   endtask

   task automatic test_reset_mid_miss();
      drive_req(1'b0, 64'h6000, 64'h0, 5'd9, 1'b0, 64'h0);
      step();
      idle_inputs();
      mem2proc_response = 4'd5;
      step();
      mem2proc_response = '0;
      drive_req(1'b0, 64'h7000, 64'h0, 5'd8, 1'b0, 64'h0);
      step();
      idle_inputs();
      #1;
      checks++; if (proc2mem_command !== 2'd1) begin errors++; $display("FAIL midrst_busreq: got %0d want 1", proc2mem_command); end
      reset = 1'b1;
      #1;
      checks++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 64'h0 || lsq_req_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_outputs: got cmd%0d addr%0h rdy%0b want 0 0 0", proc2mem_command, proc2mem_addr, lsq_req_ready); end
      step();
      reset = 1'b0;
      mem2proc_tag  = 4'd5;
      mem2proc_data = 64'h99;
      #1;
      checks++; if (dc_wrB_en !== 1'b0) begin errors++; $display("FAIL late_fill_wrB: got %0b want 0", dc_wrB_en); end
      step();
      mem2proc_tag = '0;
      checks++; if (ld_resp_valid !== 1'b0) begin errors++; $display("FAIL late_fill_resp: got %0b want 0", ld_resp_valid); end
   endtask

   task automatic test_perf();
`ifdef DCTRL_PERF_CNT_EN
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b0, 64'h9000 + 64'(8 * i), 64'h0, 5'(i), 1'b1, 64'h1);
         step();
         idle_inputs();
      end
      for (int i = 0; i < 2; i++) begin
         drive_req(1'b0, 64'h8000 + 64'(8 * i), 64'h0, 5'(i), 1'b0, 64'h0);
         step();
         idle_inputs();
         mem2proc_response = 4'(i + 1);
         step();
         mem2proc_response = '0;
      end
      checks++; if (perf_hits !== 32'd3 || perf_misses !== 32'd2) begin
         errors++; $display("FAIL perf_counts: got hits %0d misses %0d want 3 2", perf_hits, perf_misses); end
`endif
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_load_miss();
      test_mshr_full();
      test_store_nofill();
      test_reset_mid_miss();
      test_perf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
